// File: rtl/seg_scan_rx_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_rx_pkg
// Shared definitions for the multiplexed 7-segment scan receiver:
//   - SYNC_STAGES : depth of the input stage (2 with SEG_SCAN_RX_SYNC_EN, else 1)
//   - PAT_0..PAT_F: a..g segment patterns (bit6 = a ... bit0 = g, 1 = lit)
//   - state_t     : scan-tracking FSM states
//   - is_onehot / onehot_idx helpers for the active-high digit select
// Configuration macro: SEG_SCAN_RX_SYNC_EN
// -----------------------------------------------------------------------------
package seg_scan_rx_pkg;

`ifdef SEG_SCAN_RX_SYNC_EN
    localparam int SYNC_STAGES = 2;
`else
    localparam int SYNC_STAGES = 1;
`endif

    localparam logic [6:0] PAT_0 = 7'b1111110;
    localparam logic [6:0] PAT_1 = 7'b0110000;
    localparam logic [6:0] PAT_2 = 7'b1101101;
    localparam logic [6:0] PAT_3 = 7'b1111001;
    localparam logic [6:0] PAT_4 = 7'b0110011;
    localparam logic [6:0] PAT_5 = 7'b1011011;
    localparam logic [6:0] PAT_6 = 7'b1011111;
    localparam logic [6:0] PAT_7 = 7'b1110000;
    localparam logic [6:0] PAT_8 = 7'b1111111;
    localparam logic [6:0] PAT_9 = 7'b1111011;
    localparam logic [6:0] PAT_A = 7'b1110111;
    localparam logic [6:0] PAT_B = 7'b0011111;
    localparam logic [6:0] PAT_C = 7'b1001110;
    localparam logic [6:0] PAT_D = 7'b0111101;
    localparam logic [6:0] PAT_E = 7'b1001111;
    localparam logic [6:0] PAT_F = 7'b1000111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    // Index of the set bit of a one-hot vector.
    function automatic logic [2:0] onehot_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg_pat_dec.sv
// -----------------------------------------------------------------------------
// seg_pat_dec
// Combinational 7-segment pattern decoder.
//   pat   [6:0] in  : a..g segment state, 1 = lit (bit6 = a)
//   val   [3:0] out : decoded hex value (0 when invalid)
//   valid       out : pattern is one of the 16 hex glyphs
// -----------------------------------------------------------------------------
module seg_pat_dec
    import seg_scan_rx_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] val,
    output logic       valid
);

    always_comb begin
        val   = 4'h0;
        valid = 1'b1;
        case (pat)
            PAT_0:   val = 4'h0;
            PAT_1:   val = 4'h1;
            PAT_2:   val = 4'h2;
            PAT_3:   val = 4'h3;
            PAT_4:   val = 4'h4;
            PAT_5:   val = 4'h5;
            PAT_6:   val = 4'h6;
            PAT_7:   val = 4'h7;
            PAT_8:   val = 4'h8;
            PAT_9:   val = 4'h9;
            PAT_A:   val = 4'hA;
            PAT_B:   val = 4'hB;
            PAT_C:   val = 4'hC;
            PAT_D:   val = 4'hD;
            PAT_E:   val = 4'hE;
            PAT_F:   val = 4'hF;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_rx.sv
// -----------------------------------------------------------------------------
// seg_scan_rx
// Receives a multiplexed 7-segment display scan (active-low segments and digit
// selects), waits for STABLE_CYC identical samples, then decodes and stores
// the digit.
//   clk                in  : clock, rising edge
//   rst                in  : asynchronous reset, active low
//   seg_n      [7:0]   in  : segments a..g on [7:1], dp on [0], active low
//   dig_sel_n  [7:0]   in  : digit select, one-hot-low when valid
//   err_clr            in  : clears err (a same-cycle new error wins)
//   digit_val  [31:0]  out : decoded nibble per digit, digit i at [4i+3:4i]
//   digit_vld  [7:0]   out : digit holds a valid value
//   dp         [7:0]   out : captured decimal point per digit, 1 = lit
//   upd                out : one-cycle pulse per valid commit
//   upd_idx    [2:0]   out : digit index of last valid commit
//   err                out : sticky undecodable-pattern flag
//   err_idx    [2:0]   out : digit index of most recent error
// Configuration macro: SEG_SCAN_RX_SYNC_EN (2-flop input synchronizer,
// otherwise a single register stage).
// -----------------------------------------------------------------------------
module seg_scan_rx
    import seg_scan_rx_pkg::*;
#(
    parameter int STABLE_CYC = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_n,
    input  logic [7:0]  dig_sel_n,
    input  logic        err_clr,
    output logic [31:0] digit_val,
    output logic [7:0]  digit_vld,
    output logic [7:0]  dp,
    output logic        upd,
    output logic [2:0]  upd_idx,
    output logic        err,
    output logic [2:0]  err_idx
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CYC - 1);

    // ---------------- input stage ----------------
    logic [7:0] seg_stage;
    logic [7:0] sel_stage;

`ifdef SEG_SCAN_RX_SYNC_EN
    logic [7:0] seg_s1_q, seg_s2_q, sel_s1_q, sel_s2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1_q <= 8'hFF;
            seg_s2_q <= 8'hFF;
            sel_s1_q <= 8'hFF;
            sel_s2_q <= 8'hFF;
        end else begin
            seg_s1_q <= seg_n;
            seg_s2_q <= seg_s1_q;
            sel_s1_q <= dig_sel_n;
            sel_s2_q <= sel_s1_q;
        end
    end

    assign seg_stage = seg_s2_q;
    assign sel_stage = sel_s2_q;
`else
    logic [7:0] seg_s1_q, sel_s1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg_s1_q <= 8'hFF;
            sel_s1_q <= 8'hFF;
        end else begin
            seg_s1_q <= seg_n;
            sel_s1_q <= dig_sel_n;
        end
    end

    assign seg_stage = seg_s1_q;
    assign sel_stage = sel_s1_q;
`endif

    // Internally everything is active high.
    logic [7:0] seg_smp, sel_smp;
    assign seg_smp = ~seg_stage;
    assign sel_smp = ~sel_stage;

    // ---------------- state ----------------
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  prev_seg_q, prev_sel_q;
    logic [31:0] digit_val_q, digit_val_d;
    logic [7:0]  digit_vld_q, digit_vld_d;
    logic [7:0]  dp_q, dp_d;
    logic        upd_q, upd_d;
    logic [2:0]  upd_idx_q, upd_idx_d;
    logic        err_q, err_d;
    logic [2:0]  err_idx_q, err_idx_d;

    // The committed data is the stable value held in prev_*; the current
    // sample may already be moving on to the next digit.
    logic [3:0] dec_val;
    logic       dec_valid;

    seg_pat_dec u_dec (
        .pat   (prev_seg_q[7:1]),
        .val   (dec_val),
        .valid (dec_valid)
    );

    logic       sel_ok, changed, commit;
    logic [2:0] commit_idx;

    always_comb begin
        sel_ok     = is_onehot(sel_smp);
        changed    = (seg_smp != prev_seg_q) || (sel_smp != prev_sel_q);
        // cnt_q == CNT_MAX means STABLE_CYC identical samples have been seen.
        commit     = (state_q == TRACK) && (cnt_q == CNT_MAX);
        commit_idx = onehot_idx(prev_sel_q);

        state_d     = state_q;
        cnt_d       = cnt_q;
        digit_val_d = digit_val_q;
        digit_vld_d = digit_vld_q;
        dp_d        = dp_q;
        upd_d       = 1'b0;
        upd_idx_d   = upd_idx_q;
        err_d       = err_q & ~err_clr;
        err_idx_d   = err_idx_q;

        if (commit) begin
            if (dec_valid) begin
                digit_val_d[commit_idx*4 +: 4] = dec_val;
                digit_vld_d[commit_idx]        = 1'b1;
                dp_d[commit_idx]               = prev_seg_q[0];
                upd_d                          = 1'b1;
                upd_idx_d                      = commit_idx;
            end else begin
                digit_vld_d[commit_idx] = 1'b0;
                err_d                   = 1'b1;
                err_idx_d               = commit_idx;
            end
        end

        if (!sel_ok) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == IDLE || changed) begin
            state_d = TRACK;
            cnt_d   = 4'd0;
        end else if (commit) begin
            state_d = HELD;
        end else if (state_q == TRACK && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            prev_seg_q  <= 8'h00;
            prev_sel_q  <= 8'h00;
            digit_val_q <= 32'd0;
            digit_vld_q <= 8'd0;
            dp_q        <= 8'd0;
            upd_q       <= 1'b0;
            upd_idx_q   <= 3'd0;
            err_q       <= 1'b0;
            err_idx_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prev_seg_q  <= seg_smp;
            prev_sel_q  <= sel_smp;
            digit_val_q <= digit_val_d;
            digit_vld_q <= digit_vld_d;
            dp_q        <= dp_d;
            upd_q       <= upd_d;
            upd_idx_q   <= upd_idx_d;
            err_q       <= err_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign digit_val = digit_val_q;
    assign digit_vld = digit_vld_q;
    assign dp        = dp_q;
    assign upd       = upd_q;
    assign upd_idx   = upd_idx_q;
    assign err       = err_q;
    assign err_idx   = err_idx_q;

endmodule
